// File: rtl/axis_frame_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_gen_pkg
// Shared definitions for the AXI-Stream frame generator:
//   state_t       - generator FSM states (CSUM is reachable only when
//                   AXIS_FRAME_GEN_CHECKSUM_EN is defined)
//   AXIS_DATA_W   - stream data width
//   pattern_word  - builds the payload word {seq[15:0], idx[15:0]}
// No ports (package).
// -----------------------------------------------------------------------------
package axis_frame_gen_pkg;

  localparam int AXIS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [AXIS_DATA_W-1:0] pattern_word(input logic [15:0] seq,
                                                          input logic [15:0] idx);
    return {seq, idx};
  endfunction

endpackage

// File: rtl/axi_stream_bus.sv
// -----------------------------------------------------------------------------
// AXI_STREAM_BUS
// Minimal AXI-Stream bundle used across the interface test systems.
//   valid, last, data - driven by the SLAVE modport (transmitting end)
//   ready             - driven by the MASTER modport (receiving end)
// Parameter DATA_W sets the data width (defaults to AXIS_DATA_W).
// -----------------------------------------------------------------------------
interface AXI_STREAM_BUS
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport SLAVE  (output valid, output last, output data, input ready);
  modport MASTER (input valid, input last, input data, output ready);

endinterface

// File: rtl/axis_frame_gen.sv
// -----------------------------------------------------------------------------
// axis_frame_gen
// Generates a burst of pattern-filled frames on an AXI-Stream output.
// Each payload word is {seq[15:0], idx[15:0]}; last marks the frame end.
//
// Ports:
//   s_axis_clk    in   single clock
//   s_axis_reset  in   synchronous active-high reset
//   start         in   one-cycle burst request, sampled only in IDLE
//   len           in   payload words per frame (0 is treated as 1)
//   frames        in   frames per burst (0 completes with no traffic)
//   busy          out  high from the cycle after an accepted start until done
//   done          out  one-cycle completion pulse
//   frame_cnt     out  frames fully accepted in the current/last burst
//   m_axis        AXI_STREAM_BUS.SLAVE stream output
//
// Build option: define AXIS_FRAME_GEN_CHECKSUM_EN to append an XOR checksum
// word to every frame (last then moves to the checksum word).
// -----------------------------------------------------------------------------
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             s_axis_clk,
  input  logic             s_axis_reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] frames,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  AXI_STREAM_BUS.SLAVE     m_axis
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t                  state;
  state_t                  state_next;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        idx;
  logic [CNT_W-1:0]        frames_q;
  logic [CNT_W-1:0]        frame_cnt_q;
  logic [15:0]             seq;
  logic                    hs;
  logic                    word_last;
  logic                    final_frame;
  logic                    axis_valid;
  logic                    axis_last;
  logic [AXIS_DATA_W-1:0]  axis_data;
  logic [AXIS_DATA_W-1:0]  word;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
  logic [AXIS_DATA_W-1:0]  csum;
`endif

  assign hs          = axis_valid && m_axis.ready;
  assign word_last   = (idx == len_q - LEN_W'(1));
  // frame_cnt_q counts completed frames, so the frame in flight is the
  // last one when exactly frames_q-1 have already completed.
  assign final_frame = (frame_cnt_q == frames_q - CNT_W'(1));
  assign word        = pattern_word(seq, 16'(idx));

  // State register
  always_ff @(posedge s_axis_clk) begin
    if (s_axis_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (frames == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (hs && word_last) begin
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = final_frame ? DONE : SEND;
`endif
        end
      end
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      CSUM: begin
        if (hs) begin
          state_next = final_frame ? DONE : SEND;
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; every term comes straight from registers, so the
  // stream outputs only move on a clock edge and hold through stalls.
  always_comb begin
    axis_valid = 1'b0;
    axis_last  = 1'b0;
    axis_data  = '0;
    case (state)
      SEND: begin
        axis_valid = 1'b1;
        axis_data  = word;
`ifndef AXIS_FRAME_GEN_CHECKSUM_EN
        axis_last  = word_last;
`endif
      end
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      CSUM: begin
        axis_valid = 1'b1;
        axis_last  = 1'b1;
        axis_data  = csum;
      end
`endif
      default: ;
    endcase
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign frame_cnt     = frame_cnt_q;
  assign m_axis.valid  = axis_valid;
  assign m_axis.last   = axis_last;
  assign m_axis.data   = axis_data;

  // Burst counters; they only advance on a handshake so the presented
  // word is frozen while ready is low.
  always_ff @(posedge s_axis_clk) begin
    if (s_axis_reset) begin
      len_q       <= LEN_W'(1);
      frames_q    <= '0;
      frame_cnt_q <= '0;
      idx         <= '0;
      seq         <= '0;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q       <= (len == '0) ? LEN_W'(1) : len;
            frames_q    <= frames;
            frame_cnt_q <= '0;
            idx         <= '0;
            seq         <= '0;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
            csum        <= '0;
`endif
          end
        end
        SEND: begin
          if (hs) begin
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
            csum <= csum ^ word;
`endif
            if (word_last) begin
              idx <= '0;
`ifndef AXIS_FRAME_GEN_CHECKSUM_EN
              frame_cnt_q <= sat_inc(frame_cnt_q);
              seq         <= seq + 16'd1;
`endif
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
        CSUM: begin
          if (hs) begin
            csum        <= '0;
            frame_cnt_q <= sat_inc(frame_cnt_q);
            seq         <= seq + 16'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;
  import axis_frame_gen_pkg::*;

  localparam int LEN_W = 16;
  localparam int CNT_W = 8;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] frames;
    int               mode;       // 0: ready high, 1: 1,0,0,1,0,1 pattern, 2: random
    logic [CNT_W-1:0] exp_fc;
    int               exp_beats;  // payload beats (checksum beats added separately)
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [CNT_W-1:0] frames = '0;
  logic             ready = 1'b0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frame_cnt;

  AXI_STREAM_BUS bus ();
  assign bus.ready = ready;

  axis_frame_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .s_axis_clk   (clk),
    .s_axis_reset (rst),
    .start        (start),
    .len          (len),
    .frames       (frames),
    .busy         (busy),
    .done         (done),
    .frame_cnt    (frame_cnt),
    .m_axis       (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    hs_cnt   = 0;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: every handshake pops one expected beat; a stalled
  // beat must not change until it is taken.
  logic        stall = 1'b0;
  logic [31:0] pdata = '0;
  logic        plast = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", {31'd0, bus.valid}, 32'd1);
        chk("stall_data", bus.data, pdata);
        chk("stall_last", {31'd0, bus.last}, {31'd0, plast});
      end
      if (bus.valid && ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus.data, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", bus.data, b.data);
          chk("beat_last", {31'd0, bus.last}, {31'd0, b.last});
        end
      end
      stall = bus.valid && !ready;
      pdata = bus.data;
      plast = bus.last;
    end
  end

  task automatic push_expected(input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] f);
    int    le;
    logic [31:0] cs;
    beat_t b;
    le = (l == 0) ? 1 : int'(l);
    for (int fr = 0; fr < int'(f); fr++) begin
      cs = '0;
      for (int i = 0; i < le; i++) begin
        b.data = {16'(fr), 16'(i)};
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
        b.last = 1'b0;
`else
        b.last = (i == le - 1);
`endif
        cs = cs ^ b.data;
        exp_q.push_back(b);
      end
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      b.data = cs;
      b.last = 1'b1;
      exp_q.push_back(b);
`endif
    end
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    logic [5:0] pat;
    pat = 6'b101001;  // k=0..5 -> 1,0,0,1,0,1
    case (mode)
      0:       return 1'b1;
      1:       return pat[k % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input vec_t v);
    int   cyc;
    int   beats;
    logic got;
    logic saw_valid;
    beats = v.exp_beats;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    beats = beats + int'(v.frames);
`endif
    hs_cnt = 0;
    push_expected(v.len, v.frames);
    start  = 1'b1;
    len    = v.len;
    frames = v.frames;
    step();
    start  = 1'b0;
    len    = LEN_W'($urandom);
    frames = CNT_W'($urandom);
    chk("busy_n1", {31'd0, busy}, 32'd1);
    chk("valid_n1", {31'd0, bus.valid}, {31'd0, (v.frames != 0)});
    cyc = 1;
    got = 1'b0;
    saw_valid = 1'b0;
    while (cyc < 400) begin
      if (bus.valid) saw_valid = 1'b1;
      if (done) begin
        got = 1'b1;
        break;
      end
      ready = pick_ready(v.mode, cyc - 1);
      step();
      cyc++;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_valid_low", {31'd0, bus.valid}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_frame_cnt", 32'(frame_cnt), 32'(v.exp_fc));
      chk("handshakes", hs_cnt, beats);
      chk("queue_empty", exp_q.size(), 32'd0);
      if (v.mode == 0) chk("done_latency", cyc, beats + 1);
      if (v.frames == 0) chk("no_valid", {31'd0, saw_valid}, 32'd0);
      step();
      chk("post_done", {31'd0, done}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("fc_hold", 32'(frame_cnt), 32'(v.exp_fc));
    end
    exp_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 16'd4, frames: 8'd2, mode: 0, exp_fc: 8'd2, exp_beats: 8};
    vecs[1] = '{len: 16'd3, frames: 8'd1, mode: 1, exp_fc: 8'd1, exp_beats: 3};
    vecs[2] = '{len: 16'd4, frames: 8'd0, mode: 0, exp_fc: 8'd0, exp_beats: 0};
    vecs[3] = '{len: 16'd0, frames: 8'd1, mode: 0, exp_fc: 8'd1, exp_beats: 1};
    vecs[4] = '{len: 16'd2, frames: 8'd3, mode: 2, exp_fc: 8'd3, exp_beats: 6};
    vecs[5] = '{len: 16'd1, frames: 8'd5, mode: 1, exp_fc: 8'd5, exp_beats: 5};
    vecs[6] = '{len: 16'd3, frames: 8'd2, mode: 0, exp_fc: 8'd2, exp_beats: 6};

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_last", {31'd0, bus.last}, 32'd0);
    chk("rst_data", bus.data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_burst(vecs[i]);
      step();
    end

    // start while busy is ignored: a second start mid-burst must not restart
    begin
      vec_t v;
      v = '{len: 16'd6, frames: 8'd1, mode: 0, exp_fc: 8'd1, exp_beats: 6};
      fork
        run_burst(v);
        begin
          repeat (3) @(posedge clk);
          #2;
          start = 1'b1;
          @(posedge clk);
          #2;
          start = 1'b0;
        end
      join
      step();
    end

    // Reset in the middle of a 5-word frame, on beat 2
    exp_q.delete();
    hs_cnt = 0;
    ready  = 1'b1;
    push_expected(16'd5, 8'd1);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    start  = 1'b1;
    len    = 16'd5;
    frames = 8'd1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_data", bus.data, 32'h0000_0002);
    rst = 1'b1;
    step();
    chk("midrst_valid", {31'd0, bus.valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_last", {31'd0, bus.last}, 32'd0);
    chk("midrst_hs", hs_cnt, 32'd2);
    chk("midrst_queue", exp_q.size(), 32'd0);
    rst = 1'b0;
    step();
    run_burst('{len: 16'd5, frames: 8'd1, mode: 0, exp_fc: 8'd1, exp_beats: 5});
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Transmitting end of the team's AXI_STREAM_BUS: a frame generator that produces a burst of framed, pattern-filled packets on a 32-bit AXI-Stream output. It honours `ready` back-pressure cycle by cycle and marks frame ends with `last`. It serves as the traffic source for stream sinks and checkers in the interface test systems.

## Interface
- `LEN_W`, 16: width of the `len` input (words per frame).
- `CNT_W`, 8: width of the `frames` input and `frame_cnt` output.
- `s_axis_clk` input 1: the single clock.
- `s_axis_reset` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request to begin a burst; sampled only in IDLE.
- `len` input LEN_W: payload words per frame; captured on accepted `start`.
- `frames` input CNT_W: number of frames in the burst; captured on accepted `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse when the burst completes.
- `frame_cnt` output CNT_W: number of frames fully accepted in the current or last burst.
- `m_axis` AXI_STREAM_BUS.SLAVE: the modport that drives `valid`, `last` and 32-bit `data`, and samples `ready`.

## Operation
- FSM states: IDLE, SEND, CSUM (present only with the macro), DONE.
- IDLE
  - `start`=1 latches `len` and `frames`, clears `frame_cnt`, word index and frame sequence.
  - If `frames`≠0, go to SEND. If `frames`=0, go to DONE with no traffic.
  - A latched `len` of 0 is treated as 1.
- SEND
  - `valid`=1.
  - `data`={seq[15:0], idx[15:0]}: seq is the frame number from 0, idx is the word number within the frame from 0.
  - `last`=1 on idx=len−1, unless CSUM is enabled.
  - Each handshake (`valid`&&`ready`) advances idx.
  - Handshake on the frame's final word:
    - Frame count not reached: increment `frame_cnt` and seq, reset idx, stay in SEND.
    - Frame count reached: go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0 from the next cycle, return to IDLE. `frame_cnt` holds its value until the next accepted `start`.
- AXI rules:
  - `valid` never depends on `ready`.
  - Once `valid` is asserted, `data` and `last` stay stable until the handshake.
  - `valid` stays low outside SEND/CSUM.
- `start` while `busy` is ignored. `len` and `frames` changes while busy are ignored.
- seq and idx wrap modulo 2^16 in the data field. `frame_cnt` saturates at its maximum.

## Timing
- Reset values: `valid`=0, `last`=0, `data`=0, `busy`=0, `done`=0, `frame_cnt`=0, state=IDLE.
- All outputs are registered. `start` at cycle N gives `valid`=1 with word 0 at N+1, and `busy`=1 at N+1.
- With `ready` held high, one word is transferred per cycle, and frames run back-to-back with no bubble between them.
- With `ready` low, the current word is held indefinitely.
- `done` is asserted in the cycle after the final handshake. `valid` drops to 0 in that same cycle.
- `frames`=0: `done` at N+1 with `valid` never asserted.
- `s_axis_reset` mid-frame: all outputs return to their reset values on the next edge. The partial frame is abandoned with no `last`.

## Configuration
- `AXIS_FRAME_GEN_CHECKSUM_EN` defined:
  - After word len−1, the CSUM state sends one extra word equal to the XOR of all payload words of that frame.
  - `last` is carried on the checksum word only.
  - Frame length on the wire is len+1.
- Not defined: CSUM state and XOR accumulator are absent, and frames are exactly len words.

## Structure
- Package `axis_frame_gen_pkg` holds:
  - the state enum `state_t` (IDLE, SEND, CSUM, DONE);
  - `AXIS_DATA_W`=32;
  - the function that builds the pattern word from seq and idx.
- No sub-module. The FSM, counters and the optional accumulator stay in one module.

## Test plan
- `len`=4, `frames`=2, `ready`=1 → 8 consecutive beats:
  - data 0x00000000..0x00000003, then 0x00010000..0x00010003;
  - `last` on beats 4 and 8;
  - `done` one cycle after beat 8;
  - `frame_cnt`=2.
- `len`=3, `frames`=1, `ready` toggled 1,0,0,1,0,1 → exactly 3 handshakes; data and `last` stable through every stall; `last` only on 0x00000002.
- `frames`=0 → `done` at N+1, `valid` never high, `frame_cnt`=0.
- `len`=0, `frames`=1 → a single beat with data 0x00000000 and `last`=1.
- Reset asserted on beat 2 of a 5-word frame → the next cycle shows `valid`=0, `busy`=0, `frame_cnt`=0. A new `start` restarts at data 0x00000000.
- With the macro, `len`=2, `frames`=1 → beats 0x00000000, 0x00000001, 0x00000001 (checksum), with `last` only on the third beat.
